// File: rtl/bf_pdep_mask_stage_if.sv
// ---------------------------------------------------------------------------
// bf_pdep_mask_stage_if
//   Output stream bundle of the PDEP mask stage (valid/ready + masked word).
//
//   Signals:
//     out_valid   FIFO head valid              (stage -> consumer)
//     out_ready   consumer accepts the head    (consumer -> stage)
//     out_data    masked word, DATA_WIDTH bits (stage -> consumer)
//     out_popcnt  popcount of the mask used    (stage -> consumer),
//                 present only when BF_MASK_POPCNT_EN is defined
//
//   Modports: master = mask stage side, slave = consumer side.
// ---------------------------------------------------------------------------
interface bf_pdep_mask_stage_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int PC_W = $clog2(DATA_WIDTH + 1);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
`ifdef BF_MASK_POPCNT_EN
  logic [PC_W-1:0]       out_popcnt;
`endif

  modport master (
    output out_valid,
    output out_data,
`ifdef BF_MASK_POPCNT_EN
    output out_popcnt,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
`ifdef BF_MASK_POPCNT_EN
    input  out_popcnt,
`endif
    output out_ready
  );
endinterface

// File: rtl/bf_pdep_mask_stage.sv
// ---------------------------------------------------------------------------
// bf_pdep_mask_stage
//   Final stage of the PDEP butterfly: ANDs the permuted word with a
//   per-entry deposit mask, buffers the result in a small FIFO and presents
//   it on a valid/ready stream. The mask index is the configuration address
//   driven into the butterfly, delayed here by BF_LATENCY cycles so it lines
//   up with the butterfly output.
//
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     addr_i                mask index, issued alongside the butterfly addr
//     dval_i, data_i        butterfly output strobe and word
//     out_if (master)       out_valid / out_ready / out_data [/ out_popcnt]
//     almost_full           upstream must stop issuing
//     overflow              sticky, a word was dropped on a full FIFO
//     bf_cfg_*              mask-table configuration write port
//
//   Optional feature macro: BF_MASK_POPCNT_EN adds out_popcnt, the popcount
//   of the mask entry applied to each word, carried through the FIFO.
// ---------------------------------------------------------------------------
module bf_pdep_mask_stage #(
  parameter int          DATA_WIDTH   = 16,
  parameter int          ADDR_WIDTH   = 2,
  parameter int          BF_LATENCY   = 2,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          AF_MARGIN    = 2,
  parameter logic [5:0]  MASK_SRAM_ID = 6'd8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic                   dval_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  bf_pdep_mask_stage_if.master   out_if,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic [5:0]             bf_cfg_sram_sel,
  input  logic [6:0]             bf_cfg_addr_write,
  input  logic                   bf_cfg_wr_en,
  input  logic [63:0]            bf_cfg_data
);

  localparam int N_ENTRIES = 1 << ADDR_WIDTH;
  localparam int N_CHUNKS  = (DATA_WIDTH + 63) / 64;
  localparam int CHUNK_W   = $clog2(N_CHUNKS);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int PC_W      = $clog2(DATA_WIDTH + 1);

  // ---------------------------------------------------------------- config
  // Low CHUNK_W bits select the 64-bit slice, everything above is the entry.
  // Keeping all upper bits lets out-of-range entries be rejected.
  logic [6:0]               cfg_entry;
  logic [6:0]               cfg_chunk;
  logic                     cfg_hit;
  logic [N_CHUNKS*64-1:0]   cfg_data_rep;
  logic [N_CHUNKS*64-1:0]   cfg_sel_rep;
  logic [DATA_WIDTH-1:0]    cfg_wdata;
  logic [DATA_WIDTH-1:0]    cfg_wmask;

  assign cfg_entry    = bf_cfg_addr_write >> CHUNK_W;
  assign cfg_chunk    = bf_cfg_addr_write & 7'((1 << CHUNK_W) - 1);
  assign cfg_hit      = bf_cfg_wr_en && (bf_cfg_sram_sel == MASK_SRAM_ID) &&
                        ({1'b0, cfg_entry} < 8'(N_ENTRIES));
  assign cfg_data_rep = {N_CHUNKS{bf_cfg_data}};

  always_comb begin
    cfg_sel_rep = '0;
    for (int c = 0; c < N_CHUNKS; c++) begin
      cfg_sel_rep[c*64 +: 64] = {64{cfg_chunk == 7'(c)}};
    end
  end

  // Bits above DATA_WIDTH are dropped, which truncates the last chunk.
  assign cfg_wdata = cfg_data_rep[DATA_WIDTH-1:0];
  assign cfg_wmask = cfg_sel_rep[DATA_WIDTH-1:0];

  // ------------------------------------------------------------ mask table
  logic [DATA_WIDTH-1:0] mask_q [N_ENTRIES];

  // NOTE: this memory is reset because its all-ones reset value is
  // functional (pass-through); the FIFO storage below is not reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < N_ENTRIES; e++) mask_q[e] <= '1;
    end else if (cfg_hit) begin
      mask_q[cfg_entry[ADDR_WIDTH-1:0]] <=
        (mask_q[cfg_entry[ADDR_WIDTH-1:0]] & ~cfg_wmask) | (cfg_wdata & cfg_wmask);
    end
  end

  // ------------------------------------------------------ address delay line
  logic [ADDR_WIDTH-1:0] addr_pipe_q [BF_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_d;

  // Not reset: every dval_i is preceded by a fresh address, so stale
  // contents are never used.
  always_ff @(posedge clk) begin
    addr_pipe_q[0] <= addr_i;
    for (int i = 1; i < BF_LATENCY; i++) addr_pipe_q[i] <= addr_pipe_q[i-1];
  end

  assign addr_d = addr_pipe_q[BF_LATENCY-1];

  // ------------------------------------------------------------ mask stage
  logic [DATA_WIDTH-1:0] lookup_mask;
  logic                  m_val_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [PC_W-1:0]       m_pc_q;

  // Reads the registered table, so a same-cycle write is seen one cycle later.
  assign lookup_mask = mask_q[addr_d];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_val_q <= 1'b0;
      m_pc_q  <= '0;
    end else begin
      m_val_q <= dval_i;
      if (dval_i) m_pc_q <= PC_W'($countones(lookup_mask));
    end
  end

  always_ff @(posedge clk) begin
    if (dval_i) m_data_q <= data_i & lookup_mask;
  end

  // ------------------------------------------------------------------ FIFO
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PC_W-1:0]       fifo_pc_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  overflow_q;
  logic                  full, pop, push_ok, drop;
  int                    free_slots;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = (count_q != '0) && out_if.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = m_val_q && (!full || pop);
  assign drop    = m_val_q && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_data_q[wr_ptr_q] <= m_data_q;
      fifo_pc_q[wr_ptr_q]   <= m_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // The word already in the mask stage counts as occupying a slot.
  always_comb begin
    free_slots  = FIFO_DEPTH - int'(count_q) - int'(m_val_q);
    almost_full = (free_slots <= AF_MARGIN);
  end

  assign overflow         = overflow_q;
  assign out_if.out_valid = (count_q != '0);
  assign out_if.out_data  = fifo_data_q[rd_ptr_q];
`ifdef BF_MASK_POPCNT_EN
  assign out_if.out_popcnt = (count_q != '0) ? fifo_pc_q[rd_ptr_q] : '0;
`endif

endmodule
